// File: rtl/hub75_panel_rx_if.sv
// Frame-buffer write port of hub75_panel_rx (master = receiver, slave = frame buffer).
// A write transfers on every cycle with wr_en && wr_ready; while wr_en=1 and wr_ready=0 the
// master holds wr_addr/wr_data and keeps wr_en high until the transfer happens.
interface hub75_panel_rx_if #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 5
);
    localparam int AW = 1 + ADDR_W + $clog2(COLS);

    logic          wr_en;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/hub75_panel_rx.sv
// HUB75 panel-side capture: oversamples shift/latch/blank, rebuilds each row, drains it to a frame buffer.
// Optional OE on-time statistics are enabled with `define HUB75_RX_OE_STATS_EN.
module hub75_panel_rx #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hub_clk,
    input  logic              hub_lat,
    input  logic              hub_oe_n,
    input  logic [ADDR_W-1:0] hub_addr,
    input  logic [2:0]        hub_rgb0,
    input  logic [2:0]        hub_rgb1,
    hub75_panel_rx_if.master  wr,
    output logic              row_done,
    output logic              err_short,
    output logic              err_long,
    output logic              err_overrun,
    input  logic              err_clr,
    output logic [15:0]       oe_cycles,
    output logic [2:0]        dbg
);
    localparam int COL_W = $clog2(COLS);
    localparam int K_W   = $clog2(COLS + 1);
    localparam int SW    = 3 + ADDR_W + 6;
    localparam logic [K_W-1:0]   K_MAX    = K_W'(COLS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    // oe_n resets to its idle (blanked) level so nothing is counted before the pin is seen
    localparam logic [SW-1:0]    SYNC_RST = {3'b001, {(ADDR_W + 6){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

    logic [SW-1:0]     sync1, sync2;
    logic              s_clk, s_lat, s_oe_n;
    logic [ADDR_W-1:0] s_addr;
    logic [5:0]        s_rgb;
    logic              clk_q, lat_q, clk_rise, lat_rise;

    logic [K_W-1:0]    k;
    logic [5:0]        cap [COLS];
    logic [5:0]        sh  [COLS];
    state_t            state_q, state_d;
    logic              h_q;
    logic [COL_W-1:0]  c_q;
    logic [ADDR_W-1:0] row_q;
    logic              accept, row_accept;

    assign {s_clk, s_lat, s_oe_n, s_addr, s_rgb} = sync2;
    assign clk_rise   = s_clk & ~clk_q;
    assign lat_rise   = s_lat & ~lat_q;
    assign row_accept = lat_rise && (state_q == IDLE);
    assign accept     = (state_q == DRAIN) && wr.wr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
            clk_q <= 1'b0;
            lat_q <= 1'b0;
        end else begin
            sync1 <= {hub_clk, hub_lat, hub_oe_n, hub_addr, hub_rgb0, hub_rgb1};
            sync2 <= sync1;
            clk_q <= s_clk;
            lat_q <= s_lat;
        end
    end

    // A latch edge takes priority over a coincident shift edge; that pixel is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= '0;
            for (int i = 0; i < COLS; i++) cap[i] <= '0;
        end else if (lat_rise) begin
            k <= '0;
        end else if (clk_rise && (k < K_MAX)) begin
            cap[k[COL_W-1:0]] <= s_rgb;
            k                 <= k + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lat_rise) state_d = DRAIN;
            DRAIN:   if (accept && h_q && (c_q == COL_LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            h_q     <= 1'b0;
            c_q     <= '0;
            row_q   <= '0;
            for (int i = 0; i < COLS; i++) sh[i] <= '0;
        end else begin
            state_q <= state_d;
            if (row_accept) begin
                row_q <= s_addr;
                for (int i = 0; i < COLS; i++) sh[i] <= cap[i];
            end
            if (accept) begin
                if (c_q == COL_LAST) begin
                    c_q <= '0;
                    h_q <= ~h_q;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
        end
    end

    assign wr.wr_en   = (state_q == DRAIN);
    assign wr.wr_addr = {h_q, row_q, c_q};
    assign wr.wr_data = h_q ? sh[c_q][2:0] : sh[c_q][5:3];
    assign row_done   = (state_q == DONE);
    assign dbg        = {s_oe_n, state_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_short   <= (err_short & ~err_clr)   | (lat_rise && (k < K_MAX));
            err_long    <= (err_long & ~err_clr)    | (clk_rise && !lat_rise && (k == K_MAX));
            err_overrun <= (err_overrun & ~err_clr) | (lat_rise && (state_q != IDLE));
        end
    end

`ifdef HUB75_RX_OE_STATS_EN
    logic [15:0] oe_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oe_cnt    <= '0;
            oe_cycles <= '0;
        end else if (row_accept) begin
            oe_cycles <= oe_cnt;
            oe_cnt    <= '0;
        end else if (!s_oe_n && (oe_cnt != 16'hFFFF)) begin
            oe_cnt <= oe_cnt + 1'b1;
        end
    end
`else
    assign oe_cycles = '0;
`endif
endmodule
